poly_op_scheduler: RTL and testbench
====================================

Name: poly_op_scheduler

Overview:
- Sequences the shared polynomial unit (address generator plus butterfly datapath) for two requesters: the keygen/sign control FSM (port 0) and the CPU command interface (port 1).
- Arbitrates requests round-robin and drives the address generator's 3-bit `sel` for the whole operation.
- Drives source/destination bank pointers and waits for `done_flag`.
- Returns a completion pulse to the owning requester and enforces the idle gap the address generator needs before its next operation.

Parameters:
- BANK_W, 3, width of each polynomial bank pointer.
- GAP_CYCLES, 2, cycles `sel` is held at 3'b000 after completion before the next grant (minimum 1).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester command valid
- req_ready  output  2  per-requester accept, combinational: high only in IDLE for the granted requester
- req_op0, req_op1  input  2 each  00 NTT, 01 INTT, 10 PWM, 11 PWA
- req_bank_a0, req_bank_a1  input  BANK_W each  operand A bank
- req_bank_b0, req_bank_b1  input  BANK_W each  operand B bank (PWM/PWA only)
- req_bank_d0, req_bank_d1  input  BANK_W each  destination bank
- sel  output  3  to address generator: 001 NTT, 100 INTT, 010 PWM, 110 PWA, 000 idle
- bank_a, bank_b, bank_d  output  BANK_W each  bank pointers to memory mux
- done_flag  input  1  completion pulse from address generator
- busy  output  1  high in any state other than IDLE
- cmp_valid  output  1  one-cycle completion pulse
- cmp_id  output  1  requester that owned the completed operation

Behaviour:
- Reset: asynchronous active-low. All outputs 0, state IDLE, round-robin pointer favours port 0, gap counter 0.
- Reset mid-operation: `sel` drops to 000 immediately; the in-flight command is discarded with no `cmp_valid`.
- States: IDLE, RUN, GAP.
- IDLE:
  - With one `req_valid` asserted, grant that port.
  - With both asserted, grant the port the pointer favours. After each grant the pointer favours the other port.
  - The transfer occurs on `req_valid & req_ready`. At that edge, register op, banks and owner id; `sel` takes its encoding and the bank outputs take the request values.
  - Next state RUN.
  - `req_ready` is 0 in RUN and GAP.
- RUN:
  - `sel` and the bank outputs are held stable every cycle. The address generator re-reads `sel[2]` and `sel` combinationally throughout the operation.
  - `bank_b` is driven for NTT/INTT too but is don't-care there.
  - On the edge where `done_flag` is sampled 1: `sel` <= 000, `cmp_valid` <= 1, `cmp_id` <= owner, gap counter <= GAP_CYCLES-1, next state GAP.
  - This registered clear guarantees the address generator samples 000 on its first IDLE cycle, so the operation is not retriggered.
- GAP:
  - `cmp_valid` is low after its single cycle.
  - The gap counter decrements each cycle; at 0, go to IDLE.
  - The bank outputs keep their last values until the next grant.
- `done_flag` is ignored in IDLE and GAP; a spurious pulse has no effect.
- `req_valid` dropping in RUN has no effect; the accepted command completes.
- Back-to-back operations: minimum spacing from the `done_flag` sample to the next `sel` assertion is GAP_CYCLES+1 cycles.
- No timeout. A missing `done_flag` leaves the block in RUN until reset.

Optional Feature:
- POLY_SCHED_PERF_EN defined: adds output `perf_busy` (32 bits) and output `perf_ops` (16 bits).
  - `perf_busy` counts cycles in RUN.
  - `perf_ops` increments on each `cmp_valid`.
  - Both saturate at all-ones and are cleared by reset only.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package poly_sched_pkg holds:
  - the op enum (NTT, INTT, PWM, PWA);
  - the SEL_* 3-bit constants (SEL_IDLE=000, SEL_NTT=001, SEL_PWM=010, SEL_PWA=110, SEL_INTT=100);
  - the state enum;
  - an op-to-sel mapping function.
- One sub-module, rr_arbiter_2: 2-input round-robin arbiter with a pointer update on the grant-accept strobe.

Test Plan:
- Port 0 NTT, banks a=1 d=1, `done_flag` after 300 cycles -> `sel`=001 from the cycle after accept until the done edge; `cmp_valid`=1 with `cmp_id`=0 for one cycle; `sel`=000 for ≥3 cycles before the next grant.
- Both ports valid simultaneously out of reset: port 0 PWA (a=2, b=3, d=4), port 1 INTT (a=5, d=5) -> port 0 granted first with `sel`=110 and banks 2/3/4; after completion and the gap, port 1 is granted with `sel`=100.
- Port 1 valid continuously while port 0 requests each time -> grants alternate 0,1,0,1 over four operations.
- `done_flag` pulsed in IDLE and in GAP -> no `cmp_valid`, no state change; `busy` stays 0 in IDLE.
- Assert `rstn`=0 mid-RUN of PWM -> `sel`=000, `busy`=0 and `req_ready` follows valid immediately after release; no `cmp_valid` for the aborted op.
- With POLY_SCHED_PERF_EN, two ops of 100 and 50 RUN cycles -> `perf_busy`=150, `perf_ops`=2.

Source files
------------

// File: rtl/poly_sched_pkg.sv
// Shared types for the polynomial-unit scheduler: op codes, address-generator
// select encodings, FSM states and the op-to-select mapping.
package poly_sched_pkg;

    typedef enum logic [1:0] {
        OP_NTT  = 2'b00,
        OP_INTT = 2'b01,
        OP_PWM  = 2'b10,
        OP_PWA  = 2'b11
    } op_e;

    localparam logic [2:0] SEL_IDLE = 3'b000;
    localparam logic [2:0] SEL_NTT  = 3'b001;
    localparam logic [2:0] SEL_PWM  = 3'b010;
    localparam logic [2:0] SEL_PWA  = 3'b110;
    localparam logic [2:0] SEL_INTT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    function automatic logic [2:0] op_to_sel(input op_e op);
        case (op)
            OP_NTT:  op_to_sel = SEL_NTT;
            OP_INTT: op_to_sel = SEL_INTT;
            OP_PWM:  op_to_sel = SEL_PWM;
            OP_PWA:  op_to_sel = SEL_PWA;
            default: op_to_sel = SEL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/poly_op_scheduler_rr_arbiter_2.sv
// Two-input round-robin arbiter; the pointer moves to the other port whenever
// a grant is accepted.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic ptr_q;

    always_comb begin
        grant_c = 2'b00;
        if (&req) begin
            grant_c = ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant_c = req;
        end
    end

    // After granting port 0 favour port 1, and vice versa
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= grant_c[0];
        end
    end

endmodule

// File: rtl/poly_op_scheduler.sv
// Sequences the shared address generator / butterfly unit for two requesters.
// Optional build macro POLY_SCHED_PERF_EN adds RUN-cycle and op-count counters.
module poly_op_scheduler
    import poly_sched_pkg::*;
#(
    parameter int unsigned BANK_W     = 3,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [BANK_W-1:0] req_bank_a0,
    input  logic [BANK_W-1:0] req_bank_a1,
    input  logic [BANK_W-1:0] req_bank_b0,
    input  logic [BANK_W-1:0] req_bank_b1,
    input  logic [BANK_W-1:0] req_bank_d0,
    input  logic [BANK_W-1:0] req_bank_d1,
    output logic [2:0]        sel,
    output logic [BANK_W-1:0] bank_a,
    output logic [BANK_W-1:0] bank_b,
    output logic [BANK_W-1:0] bank_d,
    input  logic              done_flag,
    output logic              busy,
`ifdef POLY_SCHED_PERF_EN
    output logic [31:0]       perf_busy,
    output logic [15:0]       perf_ops,
`endif
    output logic              cmp_valid,
    output logic              cmp_id
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e            state_q, state_nxt;
    logic [GAP_W-1:0]  gap_q, gap_nxt;
    logic              owner_q, owner_nxt;
    logic [2:0]        sel_nxt;
    logic [BANK_W-1:0] bank_a_nxt, bank_b_nxt, bank_d_nxt;
    logic              cmp_valid_nxt, cmp_id_nxt, busy_nxt;
    logic [1:0]        grant_c;
    logic              accept_c;
    logic              gnt_idx_c;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .accept  (accept_c),
        .grant_c (grant_c)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant_c : 2'b00;
    assign accept_c  = |(req_valid & req_ready);
    assign gnt_idx_c = grant_c[1];

    always_comb begin
        state_nxt     = state_q;
        gap_nxt       = gap_q;
        owner_nxt     = owner_q;
        sel_nxt       = sel;
        bank_a_nxt    = bank_a;
        bank_b_nxt    = bank_b;
        bank_d_nxt    = bank_d;
        cmp_valid_nxt = 1'b0;
        cmp_id_nxt    = cmp_id;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    owner_nxt  = gnt_idx_c;
                    sel_nxt    = op_to_sel(op_e'(gnt_idx_c ? req_op1 : req_op0));
                    bank_a_nxt = gnt_idx_c ? req_bank_a1 : req_bank_a0;
                    bank_b_nxt = gnt_idx_c ? req_bank_b1 : req_bank_b0;
                    bank_d_nxt = gnt_idx_c ? req_bank_d1 : req_bank_d0;
                    state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Registered clear so the address generator sees idle select
                // on its first free cycle and cannot retrigger.
                if (done_flag) begin
                    sel_nxt       = SEL_IDLE;
                    cmp_valid_nxt = 1'b1;
                    cmp_id_nxt    = owner_q;
                    gap_nxt       = GAP_W'(GAP_CYCLES - 1);
                    state_nxt     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            owner_q   <= 1'b0;
            sel       <= SEL_IDLE;
            bank_a    <= '0;
            bank_b    <= '0;
            bank_d    <= '0;
            cmp_valid <= 1'b0;
            cmp_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            gap_q     <= gap_nxt;
            owner_q   <= owner_nxt;
            sel       <= sel_nxt;
            bank_a    <= bank_a_nxt;
            bank_b    <= bank_b_nxt;
            bank_d    <= bank_d_nxt;
            cmp_valid <= cmp_valid_nxt;
            cmp_id    <= cmp_id_nxt;
            busy      <= busy_nxt;
        end
    end

`ifdef POLY_SCHED_PERF_EN
    // Saturating activity counters, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_busy <= '0;
            perf_ops  <= '0;
        end else begin
            if ((state_q == ST_RUN) && (perf_busy != '1)) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (cmp_valid && (perf_ops != '1)) begin
                perf_ops <= perf_ops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_poly_op_scheduler.sv
// Directed self-checking bench for poly_op_scheduler (GAP_CYCLES=2, BANK_W=3).
module tb_poly_op_scheduler;

    localparam int unsigned BANK_W = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_op0, req_op1;
    logic [BANK_W-1:0] req_bank_a0, req_bank_a1;
    logic [BANK_W-1:0] req_bank_b0, req_bank_b1;
    logic [BANK_W-1:0] req_bank_d0, req_bank_d1;
    logic [2:0]        sel;
    logic [BANK_W-1:0] bank_a, bank_b, bank_d;
    logic              done_flag;
    logic              busy;
    logic              cmp_valid;
    logic              cmp_id;
`ifdef POLY_SCHED_PERF_EN
    logic [31:0]       perf_busy;
    logic [15:0]       perf_ops;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    poly_op_scheduler #(.BANK_W(BANK_W), .GAP_CYCLES(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .req_bank_a0 (req_bank_a0),
        .req_bank_a1 (req_bank_a1),
        .req_bank_b0 (req_bank_b0),
        .req_bank_b1 (req_bank_b1),
        .req_bank_d0 (req_bank_d0),
        .req_bank_d1 (req_bank_d1),
        .sel         (sel),
        .bank_a      (bank_a),
        .bank_b      (bank_b),
        .bank_d      (bank_d),
        .done_flag   (done_flag),
        .busy        (busy),
`ifdef POLY_SCHED_PERF_EN
        .perf_busy   (perf_busy),
        .perf_ops    (perf_ops),
`endif
        .cmp_valid   (cmp_valid),
        .cmp_id      (cmp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RUN for n edges after accept, done sampled on the n-th edge
    task automatic run_done(input int n, input logic [2:0] exp_sel, input logic exp_id,
                            input string tag);
        int bad = 0;
        for (int i = 0; i < n - 1; i++) begin
            tick();
            if (sel !== exp_sel || cmp_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        chk({tag, "_hold"}, 32'(bad), 32'd0);
        chk({tag, "_cmp_valid"}, 32'(cmp_valid), 32'd1);
        chk({tag, "_cmp_id"}, 32'(cmp_id), 32'(exp_id));
        chk({tag, "_sel_clr"}, 32'(sel), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 16) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        req_valid   = 2'b00;
        req_op0     = 2'b00;
        req_op1     = 2'b00;
        req_bank_a0 = '0; req_bank_a1 = '0;
        req_bank_b0 = '0; req_bank_b1 = '0;
        req_bank_d0 = '0; req_bank_d1 = '0;
        done_flag   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmp_valid", 32'(cmp_valid), 32'd0);
        chk("rst_bank_a", 32'(bank_a), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rstn = 1'b1;
        tick();

        // Port 0 NTT, 300-cycle operation, then gap measurement
        req_op0 = 2'b00; req_bank_a0 = 3'd1; req_bank_d0 = 3'd1;
        req_valid = 2'b01;
        #1;
        chk("ntt_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("ntt_sel", 32'(sel), 32'h1);
        chk("ntt_busy", 32'(busy), 32'd1);
        chk("ntt_bank_a", 32'(bank_a), 32'd1);
        chk("ntt_bank_d", 32'(bank_d), 32'd1);
        chk("ntt_ready_run", 32'(req_ready), 32'd0);
        run_done(300, 3'b001, 1'b0, "ntt");
        req_valid = 2'b01;
        chk("gap0_ready", 32'(req_ready), 32'd0);
        tick();
        chk("gap1_ready", 32'(req_ready), 32'd0);
        chk("gap1_cmp_valid", 32'(cmp_valid), 32'd0);
        chk("gap1_sel", 32'(sel), 32'd0);
        chk("gap1_bank_a", 32'(bank_a), 32'd1);
        tick();
        chk("gap2_ready", 32'(req_ready), 32'h1);
        chk("gap2_busy", 32'(busy), 32'd0);
        chk("gap2_sel", 32'(sel), 32'd0);
        tick();
        req_valid = 2'b00;
        chk("b2b_sel", 32'(sel), 32'h1);
        run_done(5, 3'b001, 1'b0, "b2b");
        wait_idle("b2b");

        // Both ports valid out of reset
        do_reset();
        req_op0 = 2'b11; req_bank_a0 = 3'd2; req_bank_b0 = 3'd3; req_bank_d0 = 3'd4;
        req_op1 = 2'b01; req_bank_a1 = 3'd5; req_bank_b1 = 3'd0; req_bank_d1 = 3'd5;
        req_valid = 2'b11;
        #1;
        chk("both_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        chk("pwa_sel", 32'(sel), 32'h6);
        chk("pwa_bank_a", 32'(bank_a), 32'd2);
        chk("pwa_bank_b", 32'(bank_b), 32'd3);
        chk("pwa_bank_d", 32'(bank_d), 32'd4);
        run_done(5, 3'b110, 1'b0, "pwa");
        wait_idle("pwa");
        chk("p1_ready", 32'(req_ready), 32'h2);
        tick();
        chk("intt_sel", 32'(sel), 32'h4);
        chk("intt_bank_a", 32'(bank_a), 32'd5);
        chk("intt_bank_d", 32'(bank_d), 32'd5);
        req_valid = 2'b00;
        run_done(4, 3'b100, 1'b1, "intt");
        wait_idle("intt");

        // Continuous contention: grants alternate 0,1,0,1
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt%0d_ready", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("alt%0d_sel", i), 32'(sel), (i % 2 == 0) ? 32'h6 : 32'h4);
            run_done(3, (i % 2 == 0) ? 3'b110 : 3'b100, 1'(i % 2), $sformatf("alt%0d", i));
            wait_idle($sformatf("alt%0d", i));
        end
        req_valid = 2'b00;

        // Spurious done in IDLE
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        chk("spur_idle_cmp", 32'(cmp_valid), 32'd0);
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_sel", 32'(sel), 32'd0);
        tick();
        chk("spur_idle_cmp2", 32'(cmp_valid), 32'd0);
        chk("spur_idle_busy2", 32'(busy), 32'd0);

        // Spurious done in GAP
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        run_done(3, 3'b110, 1'b0, "gapop");
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        chk("spur_gap_cmp", 32'(cmp_valid), 32'd0);
        chk("spur_gap_busy", 32'(busy), 32'd1);
        chk("spur_gap_sel", 32'(sel), 32'd0);
        tick();
        chk("spur_gap_busy2", 32'(busy), 32'd0);
        chk("spur_gap_cmp2", 32'(cmp_valid), 32'd0);

        // Reset during PWM
        req_op0 = 2'b10; req_bank_a0 = 3'd6; req_bank_b0 = 3'd7; req_bank_d0 = 3'd1;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("pwm_sel", 32'(sel), 32'h2);
        chk("pwm_bank_b", 32'(bank_b), 32'd7);
        repeat (5) tick();
        req_valid = 2'b10;
        rstn = 1'b0;
        #1;
        chk("abort_sel", 32'(sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bank_a", 32'(bank_a), 32'd0);
        chk("abort_cmp", 32'(cmp_valid), 32'd0);
        rstn = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        chk("post_abort_sel", 32'(sel), 32'h4);
        chk("post_abort_cmp", 32'(cmp_valid), 32'd0);
        run_done(4, 3'b100, 1'b1, "post_abort");
        wait_idle("post_abort");

`ifdef POLY_SCHED_PERF_EN
        do_reset();
        chk("perf_busy_rst", perf_busy, 32'd0);
        chk("perf_ops_rst", 32'(perf_ops), 32'd0);
        req_op0 = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        run_done(100, 3'b001, 1'b0, "perf100");
        wait_idle("perf100");
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        run_done(50, 3'b001, 1'b0, "perf50");
        wait_idle("perf50");
        chk("perf_busy", perf_busy, 32'd150);
        chk("perf_ops", 32'(perf_ops), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
